// File: rtl/port_drain_pkg.sv
// Shared types and constants for the port-arbitration queue consumer.
// The port-index type is also used by the queue side.
package port_drain_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;
  localparam int BYTE_W    = 8;
  localparam int PKT_CNT_W = 16;

  typedef logic [PORT_W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_e;

endpackage

// File: rtl/port_drain_tx_byte_serializer.sv
// Word buffer plus byte index for the egress link.
// The word is presented MSB byte first. The index only moves on 'advance',
// so the presented byte holds stable while the sink stalls.
module byte_serializer
  import port_drain_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  port_idx_t         load_src,
  input  logic              advance,
  output logic [BYTE_W-1:0] cur_byte,
  output logic              first,
  output logic              last,
  output port_idx_t         src
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int IDX_W  = $clog2(NBYTES + 1);

  logic [DATA_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  port_idx_t         src_q, src_d;

  // Next-state for buffer, index and source: load wins, otherwise step the index
  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    src_d = src_q;
    if (load) begin
      buf_d = load_data;
      idx_d = '0;
      src_d = load_src;
    end else if (advance) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Buffer, index and source registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      buf_q <= '0;
      idx_q <= '0;
      src_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
      src_q <= src_d;
    end
  end

  // Byte select: index 0 maps to the most significant byte of the word
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(NBYTES - 1 - i)) begin
        cur_byte = buf_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign first = (idx_q == '0);
  assign last  = (idx_q == IDX_W'(NBYTES - 1));
  assign src   = src_q;

endmodule

// File: rtl/port_drain_tx.sv
// Consumer end of the port-arbitration queue: loads one port word per
// wr_data strobe and drains it as bytes over a valid/ready link.
// Optional trailing checksum byte: define PORT_DRAIN_CSUM_EN.
module port_drain_tx
  import port_drain_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                                clk,
  input  logic                                rst_b,
  input  logic                                wr_data,
  input  port_idx_t                           select,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    port_data,
  output logic                                data_empty,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic [BYTE_W-1:0]                   tx_byte,
  output logic                                tx_sop,
  output logic                                tx_eop,
  output port_idx_t                           tx_src,
  output logic [PKT_CNT_W-1:0]                pkt_cnt,
  output logic                                proto_err
);

  state_e                 state_q, state_d;
  logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic                   proto_err_q, proto_err_d;
  logic                   load, advance, pkt_inc;
  logic [BYTE_W-1:0]      ser_byte;
  logic                   ser_first, ser_last;
  port_idx_t              ser_src;

  byte_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk       (clk),
    .rst_b     (rst_b),
    .load      (load),
    .load_data (port_data[select]),
    .load_src  (select),
    .advance   (advance),
    .cur_byte  (ser_byte),
    .first     (ser_first),
    .last      (ser_last),
    .src       (ser_src)
  );

`ifdef PORT_DRAIN_CSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  // Running XOR of transferred data bytes, cleared on each new load
  always_comb begin
    csum_d = csum_q;
    if (load) begin
      csum_d = '0;
    end else if (state_q == SEND && tx_ready) begin
      csum_d = csum_q ^ ser_byte;
    end
  end

  // Checksum accumulator register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  // FSM next-state and egress outputs; a byte moves when tx_ready is high in SEND/CSUM
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    advance  = 1'b0;
    pkt_inc  = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = '0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_data) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_byte  = ser_byte;
        tx_sop   = ser_first;
`ifdef PORT_DRAIN_CSUM_EN
        tx_eop   = 1'b0;
`else
        tx_eop   = ser_last;
`endif
        if (tx_ready) begin
          if (ser_last) begin
`ifdef PORT_DRAIN_CSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            pkt_inc = 1'b1;
`endif
          end else begin
            advance = 1'b1;
          end
        end
      end
`ifdef PORT_DRAIN_CSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_byte  = csum_q ^ {{(BYTE_W-PORT_W){1'b0}}, ser_src};
        tx_eop   = 1'b1;
        if (tx_ready) begin
          state_d = IDLE;
          pkt_inc = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Saturating packet counter and sticky protocol-error flag
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    proto_err_d = proto_err_q;
    if (pkt_inc && (pkt_cnt_q != '1)) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
    if (wr_data && (state_q != IDLE)) begin
      proto_err_d = 1'b1;
    end
  end

  // State, counter and error registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      pkt_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_cnt_q   <= pkt_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign data_empty = (state_q == IDLE);
  assign tx_src     = ser_src;
  assign pkt_cnt    = pkt_cnt_q;
  assign proto_err  = proto_err_q;

endmodule
